// File: rtl/lpm_mem_server.sv
// lpm_mem_server: LPM prefix-table memory server; read(addr)/write(addr,data) in, resp(data) out, in order.
// Latency: read fire in cycle T -> resp__ENA in cycle T+2 when the response FIFO was empty; writes land at the edge ending the cycle.
// Backpressure: read__RDY is a registered credit check (stage + FIFO < RESP_DEPTH); writes are never stalled.
// Optional build macro LPM_MEM_SERVER_FWD_EN adds same-address write-to-read forwarding in front of the stage register.

// Small generic synchronous FIFO with valid/ready on both sides; storage is reset so the head reads 0 after reset.
module lpm_mem_server_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_fire;
  logic             pop_fire;

  assign push_rdy  = (count != FULL_CNT);
  assign pop_vld   = (count != '0);
  assign pop_dat   = buf_q[rd_ptr];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  // Entry storage: cleared on reset so the exposed head is 0, otherwise written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push_fire) begin
      buf_q[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop_fire) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

module lpm_mem_server #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  read__ENA,
  input  logic [31:0]           read_addr,
  output logic                  read__RDY,
  input  logic                  write__ENA,
  input  logic [31:0]           write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write__RDY,
  output logic                  resp__ENA,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  resp__RDY
);

  localparam int MEM_WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RESP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  read_fire;
  logic                  write_fire;
  logic                  resp_pop;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  stage_vld;
  logic [DATA_WIDTH-1:0] stage_dat;
  logic [CNT_W-1:0]      outstanding;
  logic                  fifo_push_rdy;
  logic                  unused_bits;

  // Upper address bits alias silently; only the low DEPTH_LOG2 bits index the table.
  assign rd_idx      = read_addr[DEPTH_LOG2-1:0];
  assign wr_idx      = write_addr[DEPTH_LOG2-1:0];
  assign unused_bits = ^{read_addr[31:DEPTH_LOG2], write_addr[31:DEPTH_LOG2], fifo_push_rdy};

  // Credits come from registers only, so a pop in this cycle cannot enable a read in the same cycle.
  assign read__RDY  = (outstanding < CREDIT_MAX);
  assign write__RDY = 1'b1;
  assign read_fire  = read__ENA && read__RDY;
  assign write_fire = write__ENA;
  assign resp_pop   = resp__ENA && resp__RDY;

`ifdef LPM_MEM_SERVER_FWD_EN
  // Same-cycle write to the read address wins over the stored word.
  always_comb begin
    rd_word = mem[rd_idx];
    if (write_fire && (wr_idx == rd_idx)) begin
      rd_word = write_data;
    end
  end
`else
  // Without forwarding a colliding read sees the pre-write contents.
  always_comb begin
    rd_word = mem[rd_idx];
  end
`endif

  // Table array and read stage data: not reset, memory is undefined until written.
  always_ff @(posedge CLK) begin
    if (write_fire) begin
      mem[wr_idx] <= write_data;
    end
    if (read_fire) begin
      stage_dat <= rd_word;
    end
  end

  // Stage valid follows read fire by one edge; the stage always drains into the FIFO on the next edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stage_vld <= 1'b0;
    end else begin
      stage_vld <= read_fire;
    end
  end

  // Outstanding reads (stage + FIFO): up on accept, down on delivery.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      outstanding <= '0;
    end else begin
      case ({read_fire, resp_pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credit accounting guarantees room, so the stage push is never refused.
  lpm_mem_server_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .push_vld (stage_vld),
    .push_dat (stage_dat),
    .push_rdy (fifo_push_rdy),
    .pop_vld  (resp__ENA),
    .pop_dat  (resp_data),
    .pop_rdy  (resp__RDY)
  );

endmodule

// File: tb/tb_lpm_mem_server.sv
// tb_lpm_mem_server: directed checks of the LPM memory server with hand-computed expected values.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Backpressure: exercised by holding resp__RDY low until credits run out.
module tb_lpm_mem_server;

  logic        CLK;
  logic        nRST;
  logic        read__ENA;
  logic [31:0] read_addr;
  logic        read__RDY;
  logic        write__ENA;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write__RDY;
  logic        resp__ENA;
  logic [31:0] resp_data;
  logic        resp__RDY;

  int checks;
  int failures;
  int fires;
  logic [31:0] fwd_exp;

  lpm_mem_server #(
    .DEPTH_LOG2 (10),
    .DATA_WIDTH (32),
    .RESP_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .read__ENA  (read__ENA),
    .read_addr  (read_addr),
    .read__RDY  (read__RDY),
    .write__ENA (write__ENA),
    .write_addr (write_addr),
    .write_data (write_data),
    .write__RDY (write__RDY),
    .resp__ENA  (resp__ENA),
    .resp_data  (resp_data),
    .resp__RDY  (resp__RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    write__ENA = 1'b1;
    write_addr = a;
    write_data = d;
    step();
    write__ENA = 1'b0;
  endtask

  // Single read into an empty FIFO: nothing in T+1, data in T+2, popped after.
  task automatic read_one(input string tag, input logic [31:0] a, input logic [31:0] exp);
    check({tag, "_rdy"}, {31'd0, read__RDY}, 32'd1);
    read__ENA = 1'b1;
    read_addr = a;
    step();
    read__ENA = 1'b0;
    check({tag, "_ena_t1"}, {31'd0, resp__ENA}, 32'd0);
    step();
    check({tag, "_ena_t2"}, {31'd0, resp__ENA}, 32'd1);
    check({tag, "_data"}, resp_data, exp);
    step();
    check({tag, "_drained"}, {31'd0, resp__ENA}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    nRST       = 1'b0;
    read__ENA  = 1'b0;
    read_addr  = '0;
    write__ENA = 1'b0;
    write_addr = '0;
    write_data = '0;
    resp__RDY  = 1'b1;

    // Reset values
    step();
    step();
    check("rst_resp_ena", {31'd0, resp__ENA}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_read_rdy", {31'd0, read__RDY}, 32'd1);
    check("rst_write_rdy", {31'd0, write__RDY}, 32'd1);
    nRST = 1'b1;
    step();
    check("post_rst_resp_ena", {31'd0, resp__ENA}, 32'd0);
    check("post_rst_read_rdy", {31'd0, read__RDY}, 32'd1);

    // Basic write then read twice
    do_write(32'd5, 32'hDEAD_BEEF);
    read_one("rd5_a", 32'd5, 32'hDEAD_BEEF);
    read_one("rd5_b", 32'd5, 32'hDEAD_BEEF);

    // Table fill: addr*3
    for (int i = 0; i < 16; i++) begin
      do_write(i, i * 3);
    end

    // Backpressure: continuous reads of 1,2,3,... with resp__RDY low
    resp__RDY = 1'b0;
    fires     = 0;
    read__ENA = 1'b1;
    read_addr = 32'd1;
    for (int c = 0; c < 8; c++) begin
      if (read__RDY) begin
        fires++;
      end
      step();
      if (fires > 0) begin
        read_addr = fires + 1;
      end
    end
    check("bp_fire_count", fires, 32'd4);
    check("bp_read_rdy_low", {31'd0, read__RDY}, 32'd0);
    read__ENA = 1'b0;
    check("bp_head_ena", {31'd0, resp__ENA}, 32'd1);
    check("bp_head_data", resp_data, 32'd3);
    resp__RDY = 1'b1;
    check("bp_rdy_same_cycle_pop", {31'd0, read__RDY}, 32'd0);
    step();
    check("bp_rdy_after_pop", {31'd0, read__RDY}, 32'd1);
    check("bp_resp2", resp_data, 32'd6);
    step();
    check("bp_resp3", resp_data, 32'd9);
    step();
    check("bp_resp4_ena", {31'd0, resp__ENA}, 32'd1);
    check("bp_resp4", resp_data, 32'd12);
    step();
    check("bp_empty", {31'd0, resp__ENA}, 32'd0);

    // Same-cycle write and read of one address
    do_write(32'd7, 32'h11);
`ifdef LPM_MEM_SERVER_FWD_EN
    fwd_exp = 32'h22;
`else
    fwd_exp = 32'h11;
`endif
    write__ENA = 1'b1;
    write_addr = 32'd7;
    write_data = 32'h22;
    read_one("collide7", 32'd7, fwd_exp);
    write__ENA = 1'b0;
    read_one("after7", 32'd7, 32'h22);

    // Address aliasing modulo 1024
    do_write(32'h405, 32'hA5A5_A5A5);
    read_one("alias5", 32'd5, 32'hA5A5_A5A5);
    read_one("alias805", 32'h805, 32'hA5A5_A5A5);

    // Read and write to different addresses in the same cycle
    write__ENA = 1'b1;
    write_addr = 32'd9;
    write_data = 32'h99;
    read_one("indep_rd3", 32'd3, 32'd9);
    write__ENA = 1'b0;
    read_one("indep_rd9", 32'd9, 32'h99);

    // Reset with reads in flight
    resp__RDY = 1'b0;
    read__ENA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_addr = i;
      step();
    end
    read__ENA = 1'b0;
    nRST = 1'b0;
    #1;
    check("midrst_resp_ena", {31'd0, resp__ENA}, 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_read_rdy", {31'd0, read__RDY}, 32'd1);
    step();
    check("midrst_hold_ena", {31'd0, resp__ENA}, 32'd0);
    nRST = 1'b1;
    resp__RDY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("postrst_no_stale", {31'd0, resp__ENA}, 32'd0);
    end
    check("postrst_read_rdy", {31'd0, read__RDY}, 32'd1);

    // Streaming: 16 back-to-back reads, one response per cycle
    for (int i = 0; i < 16; i++) begin
      do_write(i, i * 3);
    end
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        check("stream_rdy", {31'd0, read__RDY}, 32'd1);
        read__ENA = 1'b1;
        read_addr = c;
      end else begin
        read__ENA = 1'b0;
      end
      step();
      if (c >= 1 && c <= 16) begin
        check("stream_ena", {31'd0, resp__ENA}, 32'd1);
        check("stream_data", resp_data, (c - 1) * 3);
      end else begin
        check("stream_idle", {31'd0, resp__ENA}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
